if_id_skid_stage: RTL and testbench

- Parametrised successor to the fixed IF/ID register: moves fetch-stage payload (PC, instruction, side-band bits) into decode over a valid/ready handshake.
- Built-in 2-entry skid buffer gives full throughput with a registered in_ready.
- Adds synchronous flush and NOP masking of invalid output.
- Sits between fetch and decode; the same block is reusable for later stage boundaries.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_payload_reg.sv | 52 +++++
 rtl/if_id_skid_stage.sv | 156 +++++++++++++++
 tb/tb_if_id_skid_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage-register occupancy states, the RISC-V
// canonical NOP (addi x0, x0, 0) and default payload widths.
package pipe_pkg;

    localparam int PIPE_XLEN = 32;
    localparam int PIPE_ILEN = 32;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled {pc, instr, side} register with asynchronous reset values.
module pipe_payload_reg #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter int              SIDE_W    = 2,
    parameter logic [ILEN-1:0] RST_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [XLEN-1:0]   d_pc,
    input  logic [ILEN-1:0]   d_instr,
    input  logic [SIDE_W-1:0] d_side,
    output logic [XLEN-1:0]   q_pc,
    output logic [ILEN-1:0]   q_instr,
    output logic [SIDE_W-1:0] q_side
);

    logic [XLEN-1:0]   pc_q,    pc_d;
    logic [ILEN-1:0]   instr_q, instr_d;
    logic [SIDE_W-1:0] side_q,  side_d;

    // Capture the new payload only when loaded, otherwise hold.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        side_d  = side_q;
        if (load) begin
            pc_d    = d_pc;
            instr_d = d_instr;
            side_d  = d_side;
        end
    end

    // Payload storage; reset leaves a harmless NOP in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= RST_INSTR;
            side_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            side_q  <= side_d;
        end
    end

    assign q_pc    = pc_q;
    assign q_instr = instr_q;
    assign q_side  = side_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage register with a 2-entry skid buffer, synchronous flush and NOP
// masking of the invalid output. in_ready is a pure decode of the state
// register, so there is no combinational path from out_ready to in_ready.
// Optional macro IF_ID_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int              XLEN      = PIPE_XLEN,
    parameter int              ILEN      = PIPE_ILEN,
    parameter int              SIDE_W    = 2,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(RV_NOP),
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [ILEN-1:0]   in_instr,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [ILEN-1:0]   out_instr,
    output logic [SIDE_W-1:0] out_side,
    output logic [1:0]        occupancy
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    state_e            state_q, state_d;
    logic              in_fire, out_fire;
    logic              main_load, main_from_skid, skid_load;
    logic [XLEN-1:0]   main_d_pc,    main_pc,    skid_pc;
    logic [ILEN-1:0]   main_d_instr, main_instr, skid_instr;
    logic [SIDE_W-1:0] main_d_side,  main_side,  skid_side;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = 2'(state_q);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next state and payload steering; flush wins and drops everything held.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Main refills from the skid entry when draining TWO, else from fetch.
    always_comb begin
        main_d_pc    = in_pc;
        main_d_instr = in_instr;
        main_d_side  = in_side;
        if (main_from_skid) begin
            main_d_pc    = skid_pc;
            main_d_instr = skid_instr;
            main_d_side  = skid_side;
        end
    end

    pipe_payload_reg #(
        .XLEN(XLEN), .ILEN(ILEN), .SIDE_W(SIDE_W), .RST_INSTR(NOP_INSTR)
    ) u_main (
        .clk(clk), .rst_n(rst_n), .load(main_load),
        .d_pc(main_d_pc), .d_instr(main_d_instr), .d_side(main_d_side),
        .q_pc(main_pc), .q_instr(main_instr), .q_side(main_side)
    );

    pipe_payload_reg #(
        .XLEN(XLEN), .ILEN(ILEN), .SIDE_W(SIDE_W), .RST_INSTR(NOP_INSTR)
    ) u_skid (
        .clk(clk), .rst_n(rst_n), .load(skid_load),
        .d_pc(in_pc), .d_instr(in_instr), .d_side(in_side),
        .q_pc(skid_pc), .q_instr(skid_instr), .q_side(skid_side)
    );

    // Decode never sees stale instructions or side-band while invalid.
    always_comb begin
        out_pc    = main_pc;
        out_instr = out_valid ? main_instr : NOP_INSTR;
        out_side  = out_valid ? main_side  : '0;
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: stalled output cycles and flushes that killed work.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_i && out_valid && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage. Inputs change 1 time unit after the
// rising edge; the monitor samples on the falling edge.
module tb_if_id_skid_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  side;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n, flush_i, in_valid, out_ready;
    logic [31:0] in_pc, in_instr;
    logic [1:0]  in_side;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [1:0]  out_side, occupancy;

    int total = 0;
    int bad   = 0;
    entry_t sb[$];

    always #5 clk = ~clk;

`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  s_stall_cnt, s_flush_cnt;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc, s_out_instr;
    logic [1:0]  s_out_side, s_occupancy;
    logic [15:0] m_stall, m_flush;
    logic [1:0]  m_s_stall;
`endif

    if_id_skid_stage dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_side(in_side),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_side(out_side),
        .occupancy(occupancy)
`ifdef IF_ID_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

`ifdef IF_ID_PERF_CNT_EN
    if_id_skid_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_side(in_side),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_instr(s_out_instr), .out_side(s_out_side),
        .occupancy(s_occupancy),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [1:0] side, input logic ordy, input logic fl);
        @(posedge clk); #1;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        in_side   = side;
        out_ready = ordy;
        flush_i   = fl;
    endtask

    // Monitor: model occupancy, FIFO order, masking, stable hold and counters.
    logic        hold_pend = 1'b0;
    logic [31:0] h_pc, h_instr;
    logic [1:0]  h_side;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            hold_pend = 1'b0;
`ifdef IF_ID_PERF_CNT_EN
            m_stall = '0; m_flush = '0; m_s_stall = '0;
`endif
        end else begin
            chk("occ_model", 64'(occupancy), 64'(sb.size()));
            chk("ovalid_model", 64'(out_valid), 64'(sb.size() != 0));
            chk("iready_model", 64'(in_ready), 64'(sb.size() != 2));
            if (!out_valid) begin
                chk("mask_instr", 64'(out_instr), 64'(NOP));
                chk("mask_side", 64'(out_side), 64'(0));
            end
            if (hold_pend) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_pc", 64'(out_pc), 64'(h_pc));
                chk("hold_instr", 64'(out_instr), 64'(h_instr));
                chk("hold_side", 64'(out_side), 64'(h_side));
            end
`ifdef IF_ID_PERF_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
            chk("sat_stall", 64'(s_stall_cnt), 64'(m_s_stall));
            if (out_valid && !out_ready) begin
                if (m_stall != 16'hFFFF) m_stall++;
                if (m_s_stall != 2'b11) m_s_stall++;
            end
            if (flush_i && sb.size() != 0 && m_flush != 16'hFFFF) m_flush++;
`endif
            hold_pend = out_valid && !out_ready && !flush_i;
            h_pc = out_pc; h_instr = out_instr; h_side = out_side;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(out_pc), 64'hDEAD);
                end else begin
                    entry_t e;
                    e = sb.pop_front();
                    chk("sb_pc", 64'(out_pc), 64'(e.pc));
                    chk("sb_instr", 64'(out_instr), 64'(e.instr));
                    chk("sb_side", 64'(out_side), 64'(e.side));
                end
            end
            if (flush_i) sb.delete();
            else if (in_valid && in_ready) sb.push_back('{in_pc, in_instr, in_side});
        end
    end

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h0050_0093; in_side = 2'b01;

        // Reset held with in_valid asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ovalid", 64'(out_valid), 64'(0));
        chk("rst_iready", 64'(in_ready), 64'(1));
        chk("rst_instr", 64'(out_instr), 64'(NOP));
        chk("rst_occ", 64'(occupancy), 64'(0));
        chk("rst_pc", 64'(out_pc), 64'(0));
        chk("rst_side", 64'(out_side), 64'(0));
        rst_n = 1'b1;

        // First word one cycle after release
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("first_valid", 64'(out_valid), 64'(1));
        chk("first_pc", 64'(out_pc), 64'h100);
        chk("first_instr", 64'(out_instr), 64'h0050_0093);

        // Streaming at full rate
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 32'(4 * i), 32'h0000_0093 | 32'(i << 20), 2'(i), 1'b1, 1'b0);
            else       drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
            chk("stream_iready", 64'(in_ready), 64'(1));
            if (i > 1) chk("stream_pc", 64'(out_pc), 64'(4 * (i - 1)));
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("stream_last", 64'(out_pc), 64'hC);

        // Backpressure fills the skid entry
        drive(1'b1, 32'h10, 32'h0010_0113, 2'b01, 1'b0, 1'b0);
        drive(1'b1, 32'h14, 32'h0020_0113, 2'b10, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        chk("bp_occ", 64'(occupancy), 64'(2));
        chk("bp_iready", 64'(in_ready), 64'(0));
        chk("bp_pc", 64'(out_pc), 64'h10);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("bp_pc_held", 64'(out_pc), 64'h10);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("bp_drain1", 64'(out_pc), 64'h14);
        chk("bp_occ1", 64'(occupancy), 64'(1));
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("bp_empty", 64'(out_valid), 64'(0));

        // Flush while TWO, with a pending fetch word
        drive(1'b1, 32'h40, 32'h0030_0113, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 32'h44, 32'h0040_0113, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 32'h20, 32'h0050_0113, 2'b11, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        chk("fl_ovalid", 64'(out_valid), 64'(0));
        chk("fl_instr", 64'(out_instr), 64'(NOP));
        chk("fl_side", 64'(out_side), 64'(0));
        chk("fl_iready", 64'(in_ready), 64'(1));
        chk("fl_pc_unmasked", 64'(out_pc), 64'h40);

        // Flush in ONE discards a same-cycle accepted word
        drive(1'b1, 32'h50, 32'h0060_0113, 2'b01, 1'b0, 1'b0);
        drive(1'b1, 32'h54, 32'h0070_0113, 2'b10, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("fl1_occ", 64'(occupancy), 64'(0));

        // Simultaneous in and out fire in ONE
        drive(1'b1, 32'h60, 32'h0080_0113, 2'b00, 1'b1, 1'b0);
        drive(1'b1, 32'h30, 32'h0090_0113, 2'b01, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        chk("sim_occ", 64'(occupancy), 64'(1));
        chk("sim_pc", 64'(out_pc), 64'h30);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 2'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        repeat (4) drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("drain_empty", 64'(occupancy), 64'(0));

`ifdef IF_ID_PERF_CNT_EN
        // Counters: reset, 5 stalls, then a flush of one entry
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("cnt_rst", 64'(stall_cnt), 64'(0));
        rst_n = 1'b1;
        drive(1'b1, 32'h70, 32'h00A0_0113, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("perf_stall5", 64'(stall_cnt), 64'(5));
        chk("perf_flush1", 64'(flush_cnt), 64'(1));
        chk("perf_sat3", 64'(s_stall_cnt), 64'(3));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
